cordic_core: RTL
================

# cordic_core

- Iterative, parametrised CORDIC engine supporting rotation mode (sin/cos, vector rotate) and vectoring mode (magnitude/atan2).
- Full-circle angle range through quadrant pre-correction, arithmetic-shift datapath with guard bits, optional 1/K gain compensation with saturation, and valid/ready handshakes on both sides.
- Sits between the angle/phase generators and downstream DSP consumers.
- Successor to the fixed 16-bit, rotation-only, first-quadrant engine.

## Interface
- `W`, default 16: data and angle width. Legal range 8..32.
- `ITER`, default 16: number of micro-rotations. Legal range 1..W.
- `GAIN_COMP`, default 1: 1 = outputs scaled by 1/K; 0 = raw K-scaled outputs.
- `clk`: input, 1 bit, sole clock.
- `rstb`: input, 1 bit. Synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`: input, 1 bit. Request present.
- `in_ready`: output, 1 bit. Engine accepts a request this cycle.
- `mode`: input, 1 bit. 0 = rotation, 1 = vectoring. Sampled on accept.
- `in_x`, `in_y`: input, W bits each. Signed two's-complement vector.
- `in_z`: input, W bits. Binary angle; full circle = 2^W, 0x8000 = -pi at W=16.
- `out_valid`: output, 1 bit. Result present.
- `out_ready`: input, 1 bit. Consumer accepts the result.
- `out_x`, `out_y`: output, W bits each. Signed result vector, saturated.
- `out_z`: output, W bits. Residual angle in rotation mode; accumulated angle in vectoring mode.

## Operation
- States: IDLE, ITER, SCALE, DONE.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready`, capture the inputs with pre-correction into W+2-bit x/y registers and the W-bit z register, clear the iteration counter, and go to ITER.
  - Rotation pre-correction: if z[W-1] != z[W-2] (|z| > pi/2), negate x and y, and invert z[W-1] (z -= pi).
  - Vectoring pre-correction: if x<0, negate x and y, and set z = in_z + 2^(W-1) (mod 2^W).
  - Negating the most negative value is exact because of the guard bits.
- **ITER:** one micro-rotation per cycle, i = 0..ITER-1.
  - Direction d = +1 if (rotation: z>=0) or (vectoring: y<0); else -1.
  - x' = x - d·(y>>>i); y' = y + d·(x>>>i); z' = z - d·atan_i (mod 2^W). Shifts are arithmetic.
  - atan_i = round(atan(2^-i)·2^W / 2pi). At W=16: atan_0=8192, atan_1=4836, atan_2=2555.
  - When i = ITER-1 completes, go to SCALE.
- **SCALE:**
  - If GAIN_COMP, x,y = (v·INV_K + 2^(W-1)) >>> W, where INV_K = round(0.6072529350·2^W); 39797 at W=16.
  - Saturate to [-2^(W-1), 2^(W-1)-1], register `out_x`/`out_y`/`out_z`, set `out_valid`=1, go to DONE.
- **DONE:** outputs held stable while `out_valid && !out_ready`. On `out_valid && out_ready`, clear `out_valid`, set `in_ready`=1, go to IDLE.
  - `out_x/y/z` retain their last values after the handshake.
- `in_valid` is ignored outside IDLE. `in_*` may change freely after the accept edge.
- `mode` and the inputs are never re-sampled mid-operation.

## Timing
- Reset (`rstb`=0 at an edge): state IDLE, `in_ready`=1, `out_valid`=0, `out_x`=`out_y`=`out_z`=0, counter 0, datapath cleared.
  - Applies in any state, including mid-ITER and DONE; the aborted operation produces no output.
- Latency: accept at edge T gives `out_valid`=1 after edge T+ITER+1 (17 cycles at ITER=16).
- Throughput: one operation per ITER+3 cycles with `out_ready` tied high. No overlap of operations.
- `in_ready` and `out_valid` are registered and never both 1.
- Illegal/unused state encodings return to IDLE with the reset values.

## Structure
- Package `cordic_pkg` holds:
  - the `cordic_mode_e` enum (ROTATE, VECTOR);
  - the `cordic_state_e` enum;
  - an elaboration-time function computing INV_K(W);
  - the guard-bit constant (2).
- Sub-module `cordic_atan_rom`, parametrised by W and ITER: combinational lookup from iteration index to atan_i, table generated at elaboration.
- Saturation is a local function in `cordic_core`.

## Test plan
Defaults: W=16, ITER=16, GAIN_COMP=1; tolerance ±4 LSB on x/y and ±2 LSB on z unless stated.
- Rotation, x=16384, y=0, z=0x2000 (pi/4): out_x ≈ out_y ≈ 11585, |out_z| ≤ 2; `out_valid` exactly 17 cycles after accept.
- Rotation at the quadrant boundary, x=16384, y=0, z=0x8000 (-pi): out_x ≈ -16384, out_y ≈ 0; repeat with z=0x4001 → out_x ≈ 0, out_y ≈ 16384.
- Vectoring, x=-12000, y=-9000, z=0: out_x ≈ 15000, out_y ≈ 0, out_z ≈ 0x9A38 (-143.13°).
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` while driving `in_valid`=1 → outputs bit-stable, `in_ready`=0, no new accept; then pulse `out_ready` → next cycle `out_valid`=0, `in_ready`=1.
- Reset at iteration 5: `rstb`=0 for one edge → next cycle `in_ready`=1, `out_valid`=0, outputs 0; no `out_valid` for the aborted request.
- Saturation with GAIN_COMP=0, rotation x=y=32767, z=0: out_x=32767 and out_y=32767 (both clipped); out_x never wraps negative.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and elaboration-time constants for the CORDIC engine.
//   cordic_mode_e  - operation selected on accept (ROTATE = sin/cos, VECTOR = magnitude/atan2)
//   cordic_state_e - engine sequencing state, also exported on the debug port
//   GUARD_BITS     - extra integer bits on the x/y datapath
//   inv_k()        - round(0.6072529350 * 2^w), the 1/K gain-compensation multiplier
//   idx_width()    - width of the micro-rotation counter for a given iteration count
package cordic_pkg;

    typedef enum logic {
        ROTATE = 1'b0,
        VECTOR = 1'b1
    } cordic_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } cordic_state_e;

    // Two extra integer bits cover the K ~= 1.647 growth of a full-scale
    // diagonal vector and make negating the most negative input exact.
    localparam int GUARD_BITS = 2;

    // Integer-only rounding keeps this exact up to W = 32, where the
    // result no longer fits a 32-bit integer.
    function automatic logic [63:0] inv_k(input int w);
        logic [127:0] num;
        num = (128'd6072529350 << w) + 128'd5000000000;
        return 64'(num / 128'd10000000000);
    endfunction

    function automatic int idx_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational arctangent table for the micro-rotations.
//   idx_i  - iteration index i
//   atan_o - round(atan(2^-i) * 2^W / 2pi) as a W-bit binary angle
// The table is computed at elaboration; entries past ITER-1 read as zero.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int W    = 16,
    parameter int ITER = 16,
    localparam int IW  = idx_width(ITER)
) (
    input  logic [IW-1:0] idx_i,
    output logic [W-1:0]  atan_o
);

    localparam int DEPTH = 1 << IW;

    // Taylor series; i = 0 (t = 1) converges too slowly, so pi/4 is given directly.
    function automatic real atan_pow2(input int i);
        real t;
        real term;
        real sum;
        if (i == 0) return 0.78539816339744830962;
        t    = 1.0 / (2.0 ** i);
        term = t;
        sum  = 0.0;
        for (int k = 0; k < 40; k++) begin
            sum  = sum + (((k % 2) == 0) ? term : -term) / real'(2 * k + 1);
            term = term * t * t;
        end
        return sum;
    endfunction

    function automatic logic [W-1:0] atan_entry(input int i);
        real v;
        v = atan_pow2(i) * (2.0 ** W) / 6.28318530717958647692;
        return W'($rtoi(v + 0.5));
    endfunction

    logic [W-1:0] atan_tab [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_tab
        if (g < ITER) begin : g_used
            localparam logic [W-1:0] ENTRY = atan_entry(g);
            assign atan_tab[g] = ENTRY;
        end else begin : g_pad
            assign atan_tab[g] = '0;
        end
    end

    assign atan_o = atan_tab[idx_i];

endmodule

// File: rtl/cordic_core.sv
// cordic_core: iterative CORDIC engine, rotation (sin/cos) and vectoring (magnitude/atan2).
//   clk, rstb            - clock, synchronous active-low reset
//   in_valid/in_ready    - request handshake; mode, in_x, in_y, in_z sampled on accept
//   out_valid/out_ready  - result handshake; out_x, out_y (saturated), out_z
//   dbg_state_o          - current sequencing state
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
// the producer holds valid and payload until then, and ready/valid are registered.
// One operation at a time: IDLE -> ITER (ITER cycles) -> SCALE -> DONE -> IDLE.
module cordic_core
    import cordic_pkg::*;
#(
    parameter int W         = 16,
    parameter int ITER      = 16,
    parameter int GAIN_COMP = 1
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_y,
    input  logic [W-1:0]  in_z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_x,
    output logic [W-1:0]  out_y,
    output logic [W-1:0]  out_z,
    output cordic_state_e dbg_state_o
);

    localparam int XW = W + GUARD_BITS;
    localparam int IW = idx_width(ITER);
    localparam int PW = XW + W + 1;   // full product of x/y with the unsigned 1/K factor

    localparam logic signed [PW-1:0] INV_K_P = PW'(inv_k(W));
    localparam logic signed [PW-1:0] ROUND_K = PW'(1) << (W - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [PW-1:0] gain(input logic signed [XW-1:0] v);
        logic signed [PW-1:0] p;
        if (GAIN_COMP != 0) begin
            p = PW'(v) * INV_K_P;
            p = (p + ROUND_K) >>> W;
        end else begin
            p = PW'(v);
        end
        return p;
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[W-1:0];
        else                  return v[W-1:0];
    endfunction

    cordic_state_e        state_q, state_d;
    cordic_mode_e         mode_q, mode_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0]         z_q, z_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic                 in_ready_q, out_valid_q;

    logic                 accept, release_out, last_iter, rot_pos, pre_flip;
    logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh;
    logic [W-1:0]         atan_w;

    cordic_atan_rom #(.W(W), .ITER(ITER)) u_atan_rom (
        .idx_i  (cnt_q),
        .atan_o (atan_w)
    );

    assign accept      = in_valid && in_ready_q;
    assign release_out = out_valid_q && out_ready;
    assign last_iter   = (cnt_q == IW'(ITER - 1));

    // Pre-correction rotates the input by pi (negate x/y, flip the angle MSB)
    // so the micro-rotations only ever need to cover +-pi/2.
    assign x_ext    = XW'($signed(in_x));
    assign y_ext    = XW'($signed(in_y));
    assign pre_flip = (cordic_mode_e'(mode) == VECTOR) ? in_x[W-1] : (in_z[W-1] ^ in_z[W-2]);

    assign x_sh    = x_q >>> cnt_q;
    assign y_sh    = y_q >>> cnt_q;
    assign rot_pos = (mode_q == ROTATE) ? ~z_q[W-1] : y_q[XW-1];

    // State register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ITER;
            ST_ITER:  if (last_iter) state_d = ST_SCALE;
            ST_SCALE: state_d = ST_DONE;
            ST_DONE:  if (release_out) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready    = in_ready_q;
        out_valid   = out_valid_q;
        out_x       = out_x_q;
        out_y       = out_y_q;
        out_z       = out_z_q;
        dbg_state_o = state_q;
    end

    // Datapath next values
    always_comb begin
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        out_z_d = out_z_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d = cordic_mode_e'(mode);
                    x_d    = pre_flip ? -x_ext : x_ext;
                    y_d    = pre_flip ? -y_ext : y_ext;
                    z_d    = pre_flip ? {~in_z[W-1], in_z[W-2:0]} : in_z;
                    cnt_d  = '0;
                end
            end
            ST_ITER: begin
                if (rot_pos) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_w;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_w;
                end
                cnt_d = cnt_q + 1'b1;
            end
            ST_SCALE: begin
                out_x_d = sat(gain(x_q));
                out_y_d = sat(gain(y_q));
                out_z_d = z_q;
            end
            ST_DONE: begin
            end
            default: begin
                mode_d  = ROTATE;
                x_d     = '0;
                y_d     = '0;
                z_d     = '0;
                cnt_d   = '0;
                out_x_d = '0;
                out_y_d = '0;
                out_z_d = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rstb) begin
            mode_q  <= ROTATE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
            out_z_q <= '0;
        end else begin
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
            out_z_q <= out_z_d;
        end
    end

endmodule
